dvp_transmitter: RTL

DVP_TRANSMITTER -- requirements
Module: dvp_transmitter

---
 rtl/dvp_pkg.sv | 23 ++
 rtl/dvp_timing_gen.sv | 93 +++++++++
 rtl/dvp_transmitter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dvp_pkg.sv
// -----------------------------------------------------------------------------
// dvp_pkg
// Shared definitions for the DVP (camera-style parallel video) transmitter.
//   dvp_state_t      : transmitter FSM state encoding
//   DEF_*            : default frame timing (QVGA, RGB565, two bytes per pixel)
// -----------------------------------------------------------------------------
package dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4
  } dvp_state_t;

  localparam int DEF_H_ACTIVE     = 320;
  localparam int DEF_V_ACTIVE     = 240;
  localparam int DEF_H_BLANK      = 144;
  localparam int DEF_VSYNC_LINES  = 3;
  localparam int DEF_V_BACK_LINES = 17;

endpackage

// File: rtl/dvp_timing_gen.sv
// -----------------------------------------------------------------------------
// dvp_timing_gen
// Byte-slot timing for the DVP transmitter: pixel-clock phase, slot-in-line
// counter and line-in-frame counter, plus the strobes the FSM steers by.
//   clk_65mhz   : clock
//   rst_n_in    : asynchronous active-low reset
//   run         : high while the FSM is out of IDLE; low clears everything
//   phase       : pixel clock level (toggles every cycle while running)
//   slot_adv    : this clock edge launches the next byte slot
//   line_end    : current slot is the last slot of a line period
//   active_end  : current slot is the last href-high slot of a line
//   odd_slot    : current slot carries a low byte when inside ACTIVE
//   vsync_end   : last slot of the last vsync line
//   vback_end   : last slot of the last back-porch line
//   last_line   : current line is the final active line of the frame
// Counters describe the slot currently on the bus. Slot 0 of line 0 is
// launched by the FSM on the IDLE exit edge, so counters start at zero.
// Assumes VSYNC_LINES >= 1 and V_BACK_LINES >= 1.
// -----------------------------------------------------------------------------
module dvp_timing_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int H_BLANK      = DEF_H_BLANK,
  parameter int VSYNC_LINES  = DEF_VSYNC_LINES,
  parameter int V_BACK_LINES = DEF_V_BACK_LINES
) (
  input  logic clk_65mhz,
  input  logic rst_n_in,
  input  logic run,
  output logic phase,
  output logic slot_adv,
  output logic line_end,
  output logic active_end,
  output logic odd_slot,
  output logic vsync_end,
  output logic vback_end,
  output logic last_line
);

  localparam int LINE_SLOTS  = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME_LINES = VSYNC_LINES + V_BACK_LINES + V_ACTIVE;
  localparam int SLOT_W      = (LINE_SLOTS > 1) ? $clog2(LINE_SLOTS) : 1;
  localparam int LINE_W      = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(LINE_SLOTS - 1);
  localparam logic [SLOT_W-1:0] ACTIVE_LAST = SLOT_W'(2 * H_ACTIVE - 1);
  localparam logic [LINE_W-1:0] VSYNC_LAST  = LINE_W'(VSYNC_LINES - 1);
  localparam logic [LINE_W-1:0] VBACK_LAST  = LINE_W'(VSYNC_LINES + V_BACK_LINES - 1);
  localparam logic [LINE_W-1:0] FRAME_LAST  = LINE_W'(FRAME_LINES - 1);

  logic              phase_reg;
  logic [SLOT_W-1:0] slot_cnt_reg;
  logic [LINE_W-1:0] line_cnt_reg;

  always_ff @(posedge clk_65mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      phase_reg    <= 1'b0;
      slot_cnt_reg <= '0;
      line_cnt_reg <= '0;
    end else if (!run) begin
      phase_reg    <= 1'b0;
      slot_cnt_reg <= '0;
      line_cnt_reg <= '0;
    end else begin
      phase_reg <= ~phase_reg;
      // A new slot starts on the edge where pclk falls (phase 1 -> 0).
      if (phase_reg) begin
        if (slot_cnt_reg == SLOT_LAST) begin
          slot_cnt_reg <= '0;
          if (line_cnt_reg == FRAME_LAST) begin
            line_cnt_reg <= '0;
          end else begin
            line_cnt_reg <= line_cnt_reg + 1'b1;
          end
        end else begin
          slot_cnt_reg <= slot_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign phase      = phase_reg;
  assign slot_adv   = run && phase_reg;
  assign line_end   = (slot_cnt_reg == SLOT_LAST);
  assign active_end = (slot_cnt_reg == ACTIVE_LAST);
  assign odd_slot   = slot_cnt_reg[0];
  assign vsync_end  = line_end && (line_cnt_reg == VSYNC_LAST);
  assign vback_end  = line_end && (line_cnt_reg == VBACK_LAST);
  assign last_line  = (line_cnt_reg == FRAME_LAST);

endmodule

// File: rtl/dvp_transmitter.sv
// -----------------------------------------------------------------------------
// dvp_transmitter
// Sends RGB565 frames over an 8-bit DVP bus (pclk / vsync / href / data),
// high byte of each pixel first.
//   clk_65mhz        : clock; pclk_out runs at half this rate
//   rst_n_in         : asynchronous active-low reset
//   enable_in        : keep sending frames; sampled only at frame boundaries
//   pixel_in         : RGB565 pixel source
//   pixel_valid_in   : pixel_in is valid
//   pixel_ready_out  : one-cycle pulse; pixel_in is taken at the end of it
//   pclk_out         : pixel clock, low in IDLE
//   vsync_out        : frame sync, active high
//   href_out         : active byte qualifier
//   data_out         : byte bus, zero whenever href_out is low
//   frame_start_out  : one-cycle pulse as a frame begins
//   frame_done_out   : one-cycle pulse as a frame completes
//   underflow_out    : sticky per frame; a pixel was needed but not valid
// Bus outputs only change on the edge where pclk falls, so the receiver sees
// stable data at every pclk rising edge.
// -----------------------------------------------------------------------------
module dvp_transmitter
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int H_BLANK      = DEF_H_BLANK,
  parameter int VSYNC_LINES  = DEF_VSYNC_LINES,
  parameter int V_BACK_LINES = DEF_V_BACK_LINES
) (
  input  logic        clk_65mhz,
  input  logic        rst_n_in,
  input  logic        enable_in,
  input  logic [15:0] pixel_in,
  input  logic        pixel_valid_in,
  output logic        pixel_ready_out,
  output logic        pclk_out,
  output logic        vsync_out,
  output logic        href_out,
  output logic [7:0]  data_out,
  output logic        frame_start_out,
  output logic        frame_done_out,
  output logic        underflow_out
);

  dvp_state_t state_reg;
  logic       vsync_reg;
  logic       href_reg;
  logic [7:0] data_reg;
  logic [7:0] pix_low_reg;
  logic       ready_reg;
  logic       frame_start_reg;
  logic       frame_done_reg;
  logic       underflow_reg;

  logic run;
  logic phase;
  logic slot_adv;
  logic line_end;
  logic active_end;
  logic odd_slot;
  logic vsync_end;
  logic vback_end;
  logic last_line;
  logic launch_high;

  assign run = (state_reg != ST_IDLE);

  dvp_timing_gen #(
    .H_ACTIVE     (H_ACTIVE),
    .V_ACTIVE     (V_ACTIVE),
    .H_BLANK      (H_BLANK),
    .VSYNC_LINES  (VSYNC_LINES),
    .V_BACK_LINES (V_BACK_LINES)
  ) u_timing (
    .clk_65mhz  (clk_65mhz),
    .rst_n_in   (rst_n_in),
    .run        (run),
    .phase      (phase),
    .slot_adv   (slot_adv),
    .line_end   (line_end),
    .active_end (active_end),
    .odd_slot   (odd_slot),
    .vsync_end  (vsync_end),
    .vback_end  (vback_end),
    .last_line  (last_line)
  );

  // The next slot to launch carries the high byte of a fresh pixel.
  // Depends only on state and counters, so it is identical on the
  // pclk-rise edge and the following pclk-fall edge.
  always_comb begin
    launch_high = 1'b0;
    case (state_reg)
      ST_VBACK:  launch_high = vback_end;
      ST_ACTIVE: launch_high = odd_slot && !active_end;
      ST_HBLANK: launch_high = line_end && !last_line;
      default:   launch_high = 1'b0;
    endcase
  end

  always_ff @(posedge clk_65mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg       <= ST_IDLE;
      vsync_reg       <= 1'b0;
      href_reg        <= 1'b0;
      data_reg        <= 8'h00;
      pix_low_reg     <= 8'h00;
      ready_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      underflow_reg   <= 1'b0;
    end else begin
      ready_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_done_reg  <= 1'b0;

      if (state_reg == ST_IDLE) begin
        if (enable_in) begin
          // This edge launches slot 0 of the vsync region.
          state_reg       <= ST_VSYNC;
          frame_start_reg <= 1'b1;
          underflow_reg   <= 1'b0;
          vsync_reg       <= 1'b1;
          href_reg        <= 1'b0;
          data_reg        <= 8'h00;
        end
      end else if (!slot_adv) begin
        // pclk-rise edge: raise ready for the cycle that ends on the
        // launching edge, where pixel_in is captured.
        ready_reg <= launch_high;
      end else begin
        if (launch_high) begin
          href_reg    <= 1'b1;
          data_reg    <= pixel_valid_in ? pixel_in[15:8] : 8'h00;
          pix_low_reg <= pixel_valid_in ? pixel_in[7:0]  : 8'h00;
          if (!pixel_valid_in) begin
            underflow_reg <= 1'b1;
          end
        end

        case (state_reg)
          ST_VSYNC: begin
            if (vsync_end) begin
              state_reg <= ST_VBACK;
              vsync_reg <= 1'b0;
            end
          end
          ST_VBACK: begin
            if (vback_end) begin
              state_reg <= ST_ACTIVE;
            end
          end
          ST_ACTIVE: begin
            if (active_end) begin
              state_reg <= ST_HBLANK;
              href_reg  <= 1'b0;
              data_reg  <= 8'h00;
            end else if (!odd_slot) begin
              data_reg <= pix_low_reg;
            end
          end
          ST_HBLANK: begin
            if (line_end && last_line) begin
              frame_done_reg <= 1'b1;
              if (enable_in) begin
                state_reg       <= ST_VSYNC;
                frame_start_reg <= 1'b1;
                underflow_reg   <= 1'b0;
                vsync_reg       <= 1'b1;
              end else begin
                state_reg <= ST_IDLE;
              end
            end else if (line_end) begin
              state_reg <= ST_ACTIVE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign pclk_out        = phase;
  assign vsync_out       = vsync_reg;
  assign href_out        = href_reg;
  assign data_out        = data_reg;
  assign pixel_ready_out = ready_reg;
  assign frame_start_out = frame_start_reg;
  assign frame_done_out  = frame_done_reg;
  assign underflow_out   = underflow_reg;

endmodule
